// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Brief    : FSM state and port-owner encodings for the unified SRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } arb_state_t;

    typedef enum logic [0:0] {
        OWNER_IF = 1'b0,
        OWNER_DM = 1'b1
    } arb_owner_t;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-port I/D SRAM between the fetch and load/store
//            ports; one access at a time, fixed read latency, starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MEM_LAT      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // fetch port
    input  logic              if_req_i,
    input  logic [AW-1:0]     if_addr_i,
    input  logic              if_flush_i,
    output logic              if_rsp_valid_o,
    output logic [DW-1:0]     if_rdata_o,
    output logic              if_stall_o,
    // load/store port
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [DW/8-1:0]   dm_be_i,
    input  logic [AW-1:0]     dm_addr_i,
    input  logic [DW-1:0]     dm_wdata_i,
    output logic              dm_rsp_valid_o,
    output logic [DW-1:0]     dm_rdata_o,
    output logic              dm_stall_o,
    // SRAM side
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DW/8-1:0]   mem_be_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [DW-1:0]     mem_wdata_o,
    input  logic [DW-1:0]     mem_rdata_i
);

    localparam int c_BW = DW / 8;
    localparam int c_CW = $clog2(MEM_LAT + 1);
    localparam int c_SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [c_CW-1:0] c_CNT_LOAD   = c_CW'(MEM_LAT);
    localparam logic [c_CW-1:0] c_CNT_ONE    = c_CW'(1);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);
    localparam logic [c_SW-1:0] c_STARVE_ONE = c_SW'(1);

    arb_state_t         r_state,    w_state_nxt;
    arb_owner_t         r_owner,    w_owner_nxt;
    logic [c_CW-1:0]    r_cnt,      w_cnt_nxt;
    logic [c_SW-1:0]    r_starve,   w_starve_nxt;
    logic               r_kill,     w_kill_nxt;

    logic               r_mem_req,   w_mem_req_nxt;
    logic               r_mem_we,    w_mem_we_nxt;
    logic [c_BW-1:0]    r_mem_be,    w_mem_be_nxt;
    logic [AW-1:0]      r_mem_addr,  w_mem_addr_nxt;
    logic [DW-1:0]      r_mem_wdata, w_mem_wdata_nxt;

    logic               w_any_req;
    logic               w_pick_if;
    logic               w_resp_cycle;
    logic               w_if_rsp;
    logic               w_dm_rsp;
    logic               w_kill_inflight;

    // Data normally wins (it belongs to the older instruction) unless fetch
    // has already lost STARVE_LIMIT grants in a row.
    assign w_any_req = if_req_i | dm_req_i;
    assign w_pick_if = if_req_i & (~dm_req_i | (r_starve == c_STARVE_MAX));

    assign w_resp_cycle = ~rst & (r_state == ST_ACCESS) & (r_cnt == '0);
    assign w_if_rsp     = w_resp_cycle & (r_owner == OWNER_IF) & ~r_kill & ~if_flush_i;
    assign w_dm_rsp     = w_resp_cycle & (r_owner == OWNER_DM);

    // A killed fetch still occupies the SRAM, so the fetch port must keep
    // stalling until the abandoned read has drained.
    assign w_kill_inflight = (r_state == ST_ACCESS) & (r_owner == OWNER_IF)
                           & (r_kill | if_flush_i);

    assign if_rsp_valid_o = w_if_rsp;
    assign if_rdata_o     = w_if_rsp ? mem_rdata_i : '0;
    assign if_stall_o     = ~rst & ((if_req_i & ~w_if_rsp) | w_kill_inflight);

    assign dm_rsp_valid_o = w_dm_rsp;
    assign dm_rdata_o     = w_dm_rsp ? mem_rdata_i : '0;
    assign dm_stall_o     = ~rst & dm_req_i & ~w_dm_rsp;

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_be_o    = r_mem_be;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWNER_IF;
            r_cnt       <= '0;
            r_starve    <= '0;
            r_kill      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_cnt       <= w_cnt_nxt;
            r_starve    <= w_starve_nxt;
            r_kill      <= w_kill_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_cnt_nxt       = r_cnt;
        w_starve_nxt    = r_starve;
        w_kill_nxt      = r_kill;
        w_mem_req_nxt   = 1'b0;
        w_mem_we_nxt    = r_mem_we;
        w_mem_be_nxt    = r_mem_be;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;

        case (r_state)
            ST_IDLE: begin
                w_kill_nxt = 1'b0;
                if (!if_req_i) begin
                    w_starve_nxt = '0;
                end
                if (w_any_req) begin
                    w_state_nxt   = ST_ACCESS;
                    w_mem_req_nxt = 1'b1;
                    if (w_pick_if) begin
                        w_owner_nxt     = OWNER_IF;
                        w_mem_we_nxt    = 1'b0;
                        w_mem_be_nxt    = '1;
                        w_mem_addr_nxt  = if_addr_i;
                        w_mem_wdata_nxt = '0;
                        w_cnt_nxt       = c_CNT_LOAD;
                        w_starve_nxt    = '0;
                    end else begin
                        w_owner_nxt     = OWNER_DM;
                        w_mem_we_nxt    = dm_we_i;
                        w_mem_be_nxt    = dm_be_i;
                        w_mem_addr_nxt  = dm_addr_i;
                        w_mem_wdata_nxt = dm_wdata_i;
                        // stores are acknowledged in the strobe cycle itself
                        w_cnt_nxt       = dm_we_i ? '0 : c_CNT_LOAD;
                        if (if_req_i && (r_starve != c_STARVE_MAX)) begin
                            w_starve_nxt = r_starve + c_STARVE_ONE;
                        end
                    end
                end
            end

            ST_ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_kill_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                    if ((r_owner == OWNER_IF) && if_flush_i) begin
                        w_kill_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed scoreboard bench for mem_port_arbiter (MEM_LAT=2,
//            STARVE_LIMIT=4) with a behavioural single-port SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i, if_flush_i;
    logic [31:0] if_addr_i;
    logic        if_rsp_valid_o, if_stall_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i, dm_we_i;
    logic [3:0]  dm_be_i;
    logic [31:0] dm_addr_i, dm_wdata_i;
    logic        dm_rsp_valid_o, dm_stall_o;
    logic [31:0] dm_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    mem_port_arbiter #(
        .AW(32), .DW(32), .MEM_LAT(2), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_rsp_valid_o(if_rsp_valid_o), .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_rsp_valid_o(dm_rsp_valid_o), .dm_rdata_o(dm_rdata_o),
        .dm_stall_o(dm_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          full;
    } mem_exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        bit          chk_data;
    } rsp_exp_t;

    mem_exp_t q_mem[$];
    rsp_exp_t q_if[$];
    rsp_exp_t q_dm[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic push_mem(input int c, input logic [31:0] a, input logic we,
                            input logic [3:0] be, input logic [31:0] wd, input bit full);
        mem_exp_t e;
        e.cyc = c; e.addr = a; e.we = we; e.be = be; e.wdata = wd; e.full = full;
        q_mem.push_back(e);
    endtask

    task automatic push_if(input int c, input logic [31:0] d);
        rsp_exp_t e;
        e.cyc = c; e.data = d; e.chk_data = 1'b1;
        q_if.push_back(e);
    endtask

    task automatic push_dm(input int c, input logic [31:0] d, input bit chk);
        rsp_exp_t e;
        e.cyc = c; e.data = d; e.chk_data = chk;
        q_dm.push_back(e);
    endtask

    // Behavioural SRAM: word array, 2-cycle read pipeline, byte-enabled writes
    logic [31:0] sram [0:255];
    logic        p1_v;
    logic [31:0] p1_a;
    logic [31:0] p2_d;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_req_o && mem_we_o)
            sram[mem_addr_o[9:2]] <= merge(sram[mem_addr_o[9:2]], mem_wdata_o, mem_be_o);
        p1_v <= mem_req_o && !mem_we_o;
        p1_a <= mem_addr_o;
        p2_d <= p1_v ? sram[p1_a[9:2]] : 32'h0;
    end
    assign mem_rdata_i = p2_d;

    // Monitor / scoreboard
    mem_exp_t m_e;
    rsp_exp_t r_e;
    always @(negedge clk) begin
        if (mem_req_o) begin
            if (q_mem.size() == 0) fail_event("mem_req unexpected strobe");
            else begin
                m_e = q_mem.pop_front();
                check("mem_req cycle", cyc, m_e.cyc);
                check("mem_addr", mem_addr_o, m_e.addr);
                check("mem_we", {31'b0, mem_we_o}, {31'b0, m_e.we});
                if (m_e.full) begin
                    check("mem_be", {28'b0, mem_be_o}, {28'b0, m_e.be});
                    check("mem_wdata", mem_wdata_o, m_e.wdata);
                end
            end
        end
        if (if_rsp_valid_o) begin
            if (q_if.size() == 0) fail_event("if_rsp_valid unexpected pulse");
            else begin
                r_e = q_if.pop_front();
                check("if_rsp cycle", cyc, r_e.cyc);
                if (r_e.chk_data) check("if_rdata", if_rdata_o, r_e.data);
            end
        end
        if (dm_rsp_valid_o) begin
            if (q_dm.size() == 0) fail_event("dm_rsp_valid unexpected pulse");
            else begin
                r_e = q_dm.pop_front();
                check("dm_rsp cycle", cyc, r_e.cyc);
                if (r_e.chk_data) check("dm_rdata", dm_rdata_o, r_e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dm_rsp(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (dm_rsp_valid_o) seen = 1'b1;
        end
        if (!seen) fail_event({name, " dm response timeout"});
        tick();
    endtask

    task automatic wait_if_rsp(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (if_rsp_valid_o) seen = 1'b1;
        end
        if (!seen) fail_event({name, " if response timeout"});
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        for (int i = 0; i < 256; i++) sram[i] = 32'h0;
        sram[32'h10 >> 2]  = 32'h0050_0093;
        sram[32'h40 >> 2]  = 32'h1122_3344;
        sram[32'h60 >> 2]  = 32'hBAD0_0BAD;
        sram[32'h80 >> 2]  = 32'h00A0_0113;
        sram[32'h100 >> 2] = 32'h0000_0013;
        for (int k = 0; k < 6; k++) sram[(32'h200 >> 2) + k] = 32'hD000_0000 + k;

        rst = 1'b1;
        if_req_i = 0; if_addr_i = 0; if_flush_i = 0;
        dm_req_i = 0; dm_we_i = 0; dm_be_i = 0; dm_addr_i = 0; dm_wdata_i = 0;

        // reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst mem_req", {31'b0, mem_req_o}, 32'h0);
        check("rst mem_we", {31'b0, mem_we_o}, 32'h0);
        check("rst mem_be", {28'b0, mem_be_o}, 32'h0);
        check("rst mem_addr", mem_addr_o, 32'h0);
        check("rst mem_wdata", mem_wdata_o, 32'h0);
        check("rst if_rsp_valid", {31'b0, if_rsp_valid_o}, 32'h0);
        check("rst if_stall", {31'b0, if_stall_o}, 32'h0);
        check("rst dm_rsp_valid", {31'b0, dm_rsp_valid_o}, 32'h0);
        check("rst dm_stall", {31'b0, dm_stall_o}, 32'h0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // 1: single fetch, MEM_LAT+2 occupancy
        c0 = cyc;
        if_req_i = 1; if_addr_i = 32'h10;
        push_mem(c0 + 1, 32'h10, 1'b0, 4'h0, 32'h0, 1'b0);
        push_if(c0 + 3, 32'h0050_0093);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t1 if_stall", {31'b0, if_stall_o}, (k < 3) ? 32'h1 : 32'h0);
        end
        tick();
        if_req_i = 0;
        repeat (2) tick();

        // 2: store acked in strobe cycle, back-to-back load; fetch flush does not touch data
        c0 = cyc;
        dm_req_i = 1; dm_we_i = 1; dm_be_i = 4'b0011; dm_addr_i = 32'h40; dm_wdata_i = 32'hABCD;
        push_mem(c0 + 1, 32'h40, 1'b1, 4'b0011, 32'hABCD, 1'b1);
        push_dm(c0 + 1, 32'h0, 1'b0);
        @(negedge clk);
        check("t2 dm_stall wait", {31'b0, dm_stall_o}, 32'h1);
        tick();
        @(negedge clk);
        check("t2 dm_stall rsp", {31'b0, dm_stall_o}, 32'h0);
        tick();
        dm_we_i = 0; dm_be_i = 4'hF; dm_wdata_i = 0;
        push_mem(c0 + 3, 32'h40, 1'b0, 4'h0, 32'h0, 1'b0);
        push_dm(c0 + 5, 32'h1122_ABCD, 1'b1);
        tick();
        if_flush_i = 1;
        tick();
        if_flush_i = 0;
        wait_dm_rsp("t2");
        dm_req_i = 0;
        repeat (2) tick();

        // 3: simultaneous requests, data wins
        c0 = cyc;
        if_req_i = 1; if_addr_i = 32'h10;
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h204;
        push_mem(c0 + 1, 32'h204, 1'b0, 4'h0, 32'h0, 1'b0);
        push_mem(c0 + 5, 32'h10, 1'b0, 4'h0, 32'h0, 1'b0);
        push_dm(c0 + 3, 32'hD000_0001, 1'b1);
        push_if(c0 + 7, 32'h0050_0093);
        @(negedge clk);
        check("t3 if_stall", {31'b0, if_stall_o}, 32'h1);
        check("t3 dm_stall", {31'b0, dm_stall_o}, 32'h1);
        wait_dm_rsp("t3");
        dm_req_i = 0;
        wait_if_rsp("t3");
        if_req_i = 0;
        repeat (2) tick();

        // 4: six back-to-back loads vs. a pending fetch -> starvation guard
        c0 = cyc;
        if_req_i = 1; if_addr_i = 32'h100;
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h200;
        for (int k = 0; k < 4; k++) begin
            push_mem(c0 + 1 + 4 * k, 32'h200 + 4 * k, 1'b0, 4'h0, 32'h0, 1'b0);
            push_dm(c0 + 3 + 4 * k, 32'hD000_0000 + k, 1'b1);
        end
        push_mem(c0 + 17, 32'h100, 1'b0, 4'h0, 32'h0, 1'b0);
        push_if(c0 + 19, 32'h0000_0013);
        for (int k = 4; k < 6; k++) begin
            push_mem(c0 + 5 + 4 * k, 32'h200 + 4 * k, 1'b0, 4'h0, 32'h0, 1'b0);
            push_dm(c0 + 7 + 4 * k, 32'hD000_0000 + k, 1'b1);
        end
        push_mem(c0 + 29, 32'h100, 1'b0, 4'h0, 32'h0, 1'b0);
        push_if(c0 + 31, 32'h0000_0013);
        for (int k = 0; k < 6; k++) begin
            wait_dm_rsp("t4");
            if (k < 5) dm_addr_i = 32'h200 + 4 * (k + 1);
            else       dm_req_i = 0;
        end
        wait_if_rsp("t4");
        if_req_i = 0;
        repeat (2) tick();

        // 5: flush mid-flight kills the fetch, redirected fetch follows
        c0 = cyc;
        if_req_i = 1; if_addr_i = 32'h60;
        push_mem(c0 + 1, 32'h60, 1'b0, 4'h0, 32'h0, 1'b0);
        tick();
        @(negedge clk);
        check("t5 if_stall c1", {31'b0, if_stall_o}, 32'h1);
        tick();
        if_flush_i = 1; if_req_i = 0; if_addr_i = 32'h80;
        tick();
        if_flush_i = 0;
        @(negedge clk);
        check("t5 if_stall killed", {31'b0, if_stall_o}, 32'h1);
        check("t5 if_rsp_valid killed", {31'b0, if_rsp_valid_o}, 32'h0);
        tick();
        if_req_i = 1;
        push_mem(c0 + 5, 32'h80, 1'b0, 4'h0, 32'h0, 1'b0);
        push_if(c0 + 7, 32'h00A0_0113);
        wait_if_rsp("t5");
        if_req_i = 0;
        repeat (2) tick();

        // 5b: flush in the response cycle itself
        c0 = cyc;
        if_req_i = 1; if_addr_i = 32'h10;
        push_mem(c0 + 1, 32'h10, 1'b0, 4'h0, 32'h0, 1'b0);
        repeat (3) tick();
        if_flush_i = 1;
        @(negedge clk);
        check("t5b if_rsp_valid", {31'b0, if_rsp_valid_o}, 32'h0);
        check("t5b if_rdata", if_rdata_o, 32'h0);
        tick();
        if_flush_i = 0; if_req_i = 0;
        repeat (2) tick();

        // 6: reset during a load abandons it; held request is re-granted
        c0 = cyc;
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h208;
        push_mem(c0 + 1, 32'h208, 1'b0, 4'h0, 32'h0, 1'b0);
        repeat (2) tick();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        check("t6 mem_req", {31'b0, mem_req_o}, 32'h0);
        check("t6 mem_we", {31'b0, mem_we_o}, 32'h0);
        check("t6 mem_addr", mem_addr_o, 32'h0);
        check("t6 mem_be", {28'b0, mem_be_o}, 32'h0);
        check("t6 dm_rsp_valid", {31'b0, dm_rsp_valid_o}, 32'h0);
        push_mem(c0 + 4, 32'h208, 1'b0, 4'h0, 32'h0, 1'b0);
        push_dm(c0 + 6, 32'hD000_0002, 1'b1);
        wait_dm_rsp("t6");
        dm_req_i = 0;

        repeat (5) tick();
        check("leftover mem strobes", q_mem.size(), 32'h0);
        check("leftover if responses", q_if.size(), 32'h0);
        check("leftover dm responses", q_dm.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
